// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle core: fetch/decode/execute/memory/writeback sequencing.
// Define CTRL_PERF_CNT_EN to add the cycle_count/instr_count performance counters.
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned PERF_W     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       cond_true,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [7:0] alu_op,
    output logic [3:0] state,
    output logic       illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cycle_count,
    output logic [PERF_W-1:0] instr_count
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JR       = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [5:0] OP_RFMT = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000011;
    localparam logic [5:0] OP_BNE  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BLT  = 6'b011000;
    localparam logic [5:0] OP_BGT  = 6'b011001;
    localparam logic [5:0] OP_BGE  = 6'b011010;
    localparam logic [5:0] OP_BLE  = 6'b011011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    localparam logic [7:0] ALU_ADD  = 8'h00;
    localparam logic [7:0] ALU_SUB  = 8'h01;
    localparam logic [7:0] ALU_AND  = 8'h02;
    localparam logic [7:0] ALU_OR   = 8'h03;
    localparam logic [7:0] ALU_XOR  = 8'h04;
    localparam logic [7:0] ALU_NOR  = 8'h05;
    localparam logic [7:0] ALU_SRL  = 8'h06;
    localparam logic [7:0] ALU_SLL  = 8'h07;
    localparam logic [7:0] ALU_ADDU = 8'h08;
    localparam logic [7:0] ALU_SUBU = 8'h09;
    localparam logic [7:0] ALU_BEQ  = 8'h10;
    localparam logic [7:0] ALU_BNE  = 8'h11;
    localparam logic [7:0] ALU_BLT  = 8'h12;
    localparam logic [7:0] ALU_BGT  = 8'h13;
    localparam logic [7:0] ALU_BGE  = 8'h14;
    localparam logic [7:0] ALU_BLE  = 8'h15;

    localparam int unsigned CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    logic [3:0]    state_reg, state_next;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          waiting;
    logic [7:0]    r_op, i_op, br_op;
    logic          r_legal, i_legal, br_legal;

    always_comb begin
        r_op    = ALU_ADD;
        r_legal = 1'b1;
        case (funct)
            FN_SLL:  r_op = ALU_SLL;
            FN_SRL:  r_op = ALU_SRL;
            FN_JR:   r_op = ALU_ADD;
            FN_ADD:  r_op = ALU_ADD;
            FN_ADDU: r_op = ALU_ADDU;
            FN_SUB:  r_op = ALU_SUB;
            FN_SUBU: r_op = ALU_SUBU;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_XOR:  r_op = ALU_XOR;
            FN_NOR:  r_op = ALU_NOR;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        i_op    = ALU_ADD;
        i_legal = 1'b1;
        case (opcode)
            OP_ADDI: i_op = ALU_ADD;
            OP_ANDI: i_op = ALU_AND;
            OP_ORI:  i_op = ALU_OR;
            OP_XORI: i_op = ALU_XOR;
            default: i_legal = 1'b0;
        endcase
    end

    always_comb begin
        br_op    = ALU_BEQ;
        br_legal = 1'b1;
        case (opcode)
            OP_BEQ:  br_op = ALU_BEQ;
            OP_BNE:  br_op = ALU_BNE;
            OP_BLT:  br_op = ALU_BLT;
            OP_BGT:  br_op = ALU_BGT;
            OP_BGE:  br_op = ALU_BGE;
            OP_BLE:  br_op = ALU_BLE;
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        waiting    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
                else           waiting    = 1'b1;
            end
            S_DECODE: begin
                if (opcode == OP_RFMT) begin
                    if (!r_legal)            state_next = S_TRAP;
                    else if (funct == FN_JR) state_next = S_JR;
                    else                     state_next = S_EXEC_R;
                end else if (i_legal) begin
                    state_next = S_EXEC_I;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_MEM_ADDR;
                end else if (br_legal) begin
                    state_next = S_BRANCH;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
            S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) state_next = S_WB_MEM;
                else           waiting    = 1'b1;
            end
            S_MEM_WR: begin
                if (mem_ready) state_next = S_FETCH;
                else           waiting    = 1'b1;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JR: state_next = S_FETCH;
            S_TRAP: state_next = S_TRAP;
            // Codes 12..15 are unreachable; treat a corrupted state as a trap.
            default: state_next = S_TRAP;
        endcase
        if (WAIT_LIMIT > 0 && waiting && (32'(wait_cnt_reg) + 32'd1) >= WAIT_LIMIT)
            state_next = S_TRAP;
    end

    always_comb begin
        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if (waiting && WAIT_LIMIT > 0)
            wait_cnt_next = wait_cnt_reg + CW'(1);
        else
            wait_cnt_next = wait_cnt_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Outputs are gated by rst_n so FETCH's request lines stay low while reset is held.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE:  alu_src_b = 2'b11;
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = r_op;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = i_op;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = (opcode == OP_RFMT);
                    alu_op    = (opcode == OP_RFMT) ? r_op : i_op;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = br_op;
                    pc_write  = cond_true;
                    pc_src    = 2'b01;
                end
                S_JR: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                S_TRAP:  illegal = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign state = state_reg;

`ifdef CTRL_PERF_CNT_EN
    logic instr_done;
    assign instr_done = (state_next == S_FETCH) &&
                        (state_reg inside {S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JR});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state_reg != S_TRAP) cycle_count <= cycle_count + PERF_W'(1);
            if (instr_done)          instr_count <= instr_count + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus trap, reset and watchdog sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, wd_rst_n;
    logic [5:0] opcode, funct;
    logic       mem_ready, cond_true, wd_mem_ready;

    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [7:0] alu_op;
    logic [3:0] state;

    logic       wd_pc_write, wd_ir_write, wd_iord, wd_mem_read, wd_mem_write, wd_reg_write;
    logic       wd_reg_dst, wd_mem_to_reg, wd_alu_src_a, wd_illegal;
    logic [1:0] wd_pc_src, wd_alu_src_b;
    logic [7:0] wd_alu_op;
    logic [3:0] wd_state;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_count, instr_count, wd_cycle_count, wd_instr_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .cond_true(cond_true),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    multicycle_ctrl #(.WAIT_LIMIT(5)) dut_wd (
        .clk(clk), .rst_n(wd_rst_n), .opcode(6'b000000), .funct(6'b100000),
        .mem_ready(wd_mem_ready), .cond_true(1'b0),
        .pc_write(wd_pc_write), .pc_src(wd_pc_src), .ir_write(wd_ir_write), .iord(wd_iord),
        .mem_read(wd_mem_read), .mem_write(wd_mem_write), .reg_write(wd_reg_write),
        .reg_dst(wd_reg_dst), .mem_to_reg(wd_mem_to_reg), .alu_src_a(wd_alu_src_a),
        .alu_src_b(wd_alu_src_b), .alu_op(wd_alu_op), .state(wd_state), .illegal(wd_illegal)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_count(wd_cycle_count), .instr_count(wd_instr_count)
`endif
    );

    logic [5:0]  strobes;
    logic [7:0]  sels;
    logic [25:0] all_out;
    assign strobes = {pc_write, ir_write, mem_read, mem_write, reg_write, illegal};
    assign sels    = {pc_src, iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b};
    assign all_out = {strobes, sels, alu_op, state};

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       mr;
        logic       ct;
        logic [3:0] st;
        logic [5:0] stb;   // {pc_write, ir_write, mem_read, mem_write, reg_write, illegal}
        logic [7:0] sel;   // {pc_src, iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b}
        logic [7:0] alu;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // sub: FETCH, DECODE, EXEC_R, WB_ALU
        vecs.push_back('{6'b000000, 6'b100010, 1'b1, 1'b0, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b000000, 6'b100010, 1'b1, 1'b0, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b000000, 6'b100010, 1'b1, 1'b0, 4'd2,  6'b000000, 8'b00000100, 8'h01});
        vecs.push_back('{6'b000000, 6'b100010, 1'b1, 1'b0, 4'd7,  6'b000010, 8'b00010000, 8'h01});
        // lw with three wait cycles in MEM_RD
        vecs.push_back('{6'b100011, 6'b000000, 1'b1, 1'b0, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b100011, 6'b000000, 1'b1, 1'b0, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b100011, 6'b000000, 1'b1, 1'b0, 4'd4,  6'b000000, 8'b00000110, 8'h00});
        vecs.push_back('{6'b100011, 6'b000000, 1'b0, 1'b0, 4'd5,  6'b001000, 8'b00100000, 8'h00});
        vecs.push_back('{6'b100011, 6'b000000, 1'b0, 1'b0, 4'd5,  6'b001000, 8'b00100000, 8'h00});
        vecs.push_back('{6'b100011, 6'b000000, 1'b0, 1'b0, 4'd5,  6'b001000, 8'b00100000, 8'h00});
        vecs.push_back('{6'b100011, 6'b000000, 1'b1, 1'b0, 4'd5,  6'b001000, 8'b00100000, 8'h00});
        vecs.push_back('{6'b100011, 6'b000000, 1'b1, 1'b0, 4'd8,  6'b000010, 8'b00001000, 8'h00});
        // sw
        vecs.push_back('{6'b101011, 6'b000000, 1'b1, 1'b0, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b101011, 6'b000000, 1'b1, 1'b0, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b101011, 6'b000000, 1'b1, 1'b0, 4'd4,  6'b000000, 8'b00000110, 8'h00});
        vecs.push_back('{6'b101011, 6'b000000, 1'b1, 1'b0, 4'd6,  6'b000100, 8'b00100000, 8'h00});
        // bge taken
        vecs.push_back('{6'b011010, 6'b000000, 1'b1, 1'b1, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b011010, 6'b000000, 1'b1, 1'b1, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b011010, 6'b000000, 1'b1, 1'b1, 4'd9,  6'b100000, 8'b01000100, 8'h14});
        // bge not taken
        vecs.push_back('{6'b011010, 6'b000000, 1'b1, 1'b0, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b011010, 6'b000000, 1'b1, 1'b0, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b011010, 6'b000000, 1'b1, 1'b0, 4'd9,  6'b000000, 8'b01000100, 8'h14});
        // jr
        vecs.push_back('{6'b000000, 6'b001000, 1'b1, 1'b0, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b000000, 6'b001000, 1'b1, 1'b0, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b000000, 6'b001000, 1'b1, 1'b0, 4'd10, 6'b100000, 8'b10000000, 8'h00});
        // ori
        vecs.push_back('{6'b001101, 6'b000000, 1'b1, 1'b0, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b001101, 6'b000000, 1'b1, 1'b0, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b001101, 6'b000000, 1'b1, 1'b0, 4'd3,  6'b000000, 8'b00000110, 8'h03});
        vecs.push_back('{6'b001101, 6'b000000, 1'b1, 1'b0, 4'd7,  6'b000010, 8'b00000000, 8'h03});
        // sll with one fetch stall
        vecs.push_back('{6'b000000, 6'b000000, 1'b0, 1'b0, 4'd0,  6'b001000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b000000, 6'b000000, 1'b1, 1'b0, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b000000, 6'b000000, 1'b1, 1'b0, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b000000, 6'b000000, 1'b1, 1'b0, 4'd2,  6'b000000, 8'b00000100, 8'h07});
        vecs.push_back('{6'b000000, 6'b000000, 1'b1, 1'b0, 4'd7,  6'b000010, 8'b00010000, 8'h07});
        // illegal opcode
        vecs.push_back('{6'b111111, 6'b000000, 1'b1, 1'b0, 4'd0,  6'b111000, 8'b00000001, 8'h00});
        vecs.push_back('{6'b111111, 6'b000000, 1'b1, 1'b0, 4'd1,  6'b000000, 8'b00000011, 8'h00});
        vecs.push_back('{6'b111111, 6'b000000, 1'b1, 1'b0, 4'd11, 6'b000001, 8'b00000000, 8'h00});

        rst_n = 1'b0; wd_rst_n = 1'b0;
        opcode = 6'd0; funct = 6'd0; mem_ready = 1'b1; cond_true = 1'b1; wd_mem_ready = 1'b0;
        repeat (2) next_cycle();
        check("reset all outputs", 32'(all_out), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op; funct = vecs[i].fn;
            mem_ready = vecs[i].mr; cond_true = vecs[i].ct;
            #1;
            check($sformatf("vec%0d state", i),   32'(state),   32'(vecs[i].st));
            check($sformatf("vec%0d strobes", i), 32'(strobes), 32'(vecs[i].stb));
            check($sformatf("vec%0d selects", i), 32'(sels),    32'(vecs[i].sel));
            check($sformatf("vec%0d alu_op", i),  32'(alu_op),  32'(vecs[i].alu));
            next_cycle();
        end

`ifdef CTRL_PERF_CNT_EN
        check("cycle_count after table", cycle_count, 32'd36);
        check("instr_count after table", instr_count, 32'd8);
`endif

        // TRAP is absorbing regardless of inputs
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0]; opcode = 6'(i);
            #1;
            check($sformatf("trap hold %0d", i), 32'({state, illegal}), 32'({4'd11, 1'b1}));
            next_cycle();
        end
`ifdef CTRL_PERF_CNT_EN
        check("cycle_count frozen in trap", cycle_count, 32'd36);
`endif

        rst_n = 1'b0;
        #1;
        check("trap reset outputs", 32'(all_out), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("counters reset", cycle_count | instr_count, 32'd0);
`endif
        next_cycle();
        rst_n = 1'b1;

        // sw, then async reset while waiting in MEM_WR
        opcode = 6'b101011; funct = 6'd0; mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
        next_cycle();
        check("mem_wr reached", 32'({state, mem_write, iord}), 32'({4'd6, 1'b1, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset mid mem_wr", 32'(all_out), 32'd0);
        mem_ready = 1'b1;
        next_cycle();
        check("reset held across edge", 32'(all_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check("fetch after reset", 32'({state, mem_read, ir_write}), 32'({4'd0, 1'b1, 1'b1}));

        // Watchdog: trips after five stalled FETCH cycles; the WAIT_LIMIT=0 copy never does
        mem_ready = 1'b0;
        wd_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("wd fetch wait %0d", i), 32'(wd_state), 32'd0);
            next_cycle();
        end
        check("wd trapped", 32'({wd_state, wd_illegal}), 32'({4'd11, 1'b1}));
        repeat (5) next_cycle();
        check("no watchdog when limit 0", 32'({state, illegal}), 32'({4'd0, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
